// File: rtl/conway_gen_ctrl.sv
// ============================================================================
// Module      : conway_gen_ctrl
// Description : Steps one Life generation across a double-banked row memory
//               using a three-row window that feeds a row of conway_cell units.
//               Optional macro CONWAY_WRAP_EN makes the column edges toroidal.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conway_cell (
    input  logic [2:0] i_top,
    input  logic [2:0] i_mid,
    input  logic [2:0] i_bot,
    output logic       o_next
);
    logic [3:0] w_count;

    assign w_count = 4'(i_top[0]) + 4'(i_top[1]) + 4'(i_top[2])
                   + 4'(i_mid[0]) + 4'(i_mid[2])
                   + 4'(i_bot[0]) + 4'(i_bot[1]) + 4'(i_bot[2]);

    assign o_next = (w_count == 4'd3) || (i_mid[1] && (w_count == 4'd2));
endmodule

module conway_gen_ctrl #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic                     bank,
    output logic [15:0]              gen_count,
    output logic                     rd_en,
    output logic [$clog2(HEIGHT):0]  rd_addr,
    input  logic [WIDTH-1:0]         rd_data,
    output logic                     wr_en,
    output logic [$clog2(HEIGHT):0]  wr_addr,
    output logic [WIDTH-1:0]         wr_data
);
    localparam int ROW_W = $clog2(HEIGHT);
    localparam logic [ROW_W:0]   c_height   = (ROW_W+1)'(HEIGHT);
    localparam logic [ROW_W-1:0] c_last_row = ROW_W'(HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PRIME0 = 3'd1,
        S_PRIME1 = 3'd2,
        S_PRIME2 = 3'd3,
        S_PRIME3 = 3'd4,
        S_EMIT   = 3'd5,
        S_FILL   = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_top;
    logic [WIDTH-1:0]     r_mid;
    logic [WIDTH-1:0]     r_bot;
    logic [ROW_W-1:0]     r_row;
    logic                 r_bank;
    logic [15:0]          r_gen_count;
    logic [ROW_W-1:0]     w_rd_row;
    logic [ROW_W:0]       w_row_p2;
    logic [ROW_W:0]       w_row_p2_wrap;
    logic [WIDTH+1:0]     w_top_ext;
    logic [WIDTH+1:0]     w_mid_ext;
    logic [WIDTH+1:0]     w_bot_ext;

    // One extra bit keeps r+2 exact before the modulo for non-power-of-two heights.
    assign w_row_p2      = {1'b0, r_row} + (ROW_W+1)'(2);
    assign w_row_p2_wrap = (w_row_p2 >= c_height) ? (w_row_p2 - c_height) : w_row_p2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = (r_state != S_IDLE);
        done         = 1'b0;
        rd_en        = 1'b0;
        wr_en        = 1'b0;
        w_rd_row     = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = S_PRIME0;
                end
            end
            S_PRIME0: begin
                rd_en        = 1'b1;
                w_rd_row     = c_last_row;
                w_next_state = S_PRIME1;
            end
            S_PRIME1: begin
                rd_en        = 1'b1;
                w_rd_row     = '0;
                w_next_state = S_PRIME2;
            end
            S_PRIME2: begin
                rd_en        = 1'b1;
                w_rd_row     = ROW_W'(1);
                w_next_state = S_PRIME3;
            end
            S_PRIME3: begin
                w_next_state = S_EMIT;
            end
            S_EMIT: begin
                wr_en = 1'b1;
                if (r_row != c_last_row) begin
                    rd_en        = 1'b1;
                    w_rd_row     = w_row_p2_wrap[ROW_W-1:0];
                    w_next_state = S_FILL;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            S_FILL: begin
                w_next_state = S_EMIT;
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_top       <= '0;
            r_mid       <= '0;
            r_bot       <= '0;
            r_row       <= '0;
            r_bank      <= 1'b0;
            r_gen_count <= '0;
        end else begin
            case (r_state)
                S_PRIME1: r_top <= rd_data;
                S_PRIME2: r_mid <= rd_data;
                S_PRIME3: begin
                    r_bot <= rd_data;
                    r_row <= '0;
                end
                S_EMIT: begin
                    r_top <= r_mid;
                    r_mid <= r_bot;
                end
                S_FILL: begin
                    r_bot <= rd_data;
                    r_row <= r_row + ROW_W'(1);
                end
                S_DONE: begin
                    r_bank      <= ~r_bank;
                    r_gen_count <= r_gen_count + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign bank      = r_bank;
    assign gen_count = r_gen_count;
    assign rd_addr   = rd_en ? {r_bank, w_rd_row} : '0;
    assign wr_addr   = wr_en ? {~r_bank, r_row} : '0;

    // Bit k of each extended row holds column k-1, so cell j sees ext[j+2:j].
`ifdef CONWAY_WRAP_EN
    assign w_top_ext = {r_top[0], r_top, r_top[WIDTH-1]};
    assign w_mid_ext = {r_mid[0], r_mid, r_mid[WIDTH-1]};
    assign w_bot_ext = {r_bot[0], r_bot, r_bot[WIDTH-1]};
`else
    assign w_top_ext = {1'b0, r_top, 1'b0};
    assign w_mid_ext = {1'b0, r_mid, 1'b0};
    assign w_bot_ext = {1'b0, r_bot, 1'b0};
`endif

    generate
        for (genvar j = 0; j < WIDTH; j++) begin : g_cell
            conway_cell u_cell (
                .i_top  (w_top_ext[j+2:j]),
                .i_mid  (w_mid_ext[j+2:j]),
                .i_bot  (w_bot_ext[j+2:j]),
                .o_next (wr_data[j])
            );
        end
    endgenerate
endmodule

`default_nettype wire

// File: tb/tb_conway_gen_ctrl.sv
// ============================================================================
// Module      : tb_conway_gen_ctrl
// Description : Self-checking bench for conway_gen_ctrl with a row-memory
//               model and a queue of expected row writes from a Life model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conway_gen_ctrl;
    localparam int W  = 32;
    localparam int H  = 24;
    localparam int RW = $clog2(H);
    localparam int AW = RW + 1;

    logic          clk   = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          busy;
    logic          done;
    logic          bank;
    logic [15:0]   gen_count;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data = '0;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    logic [W-1:0]  mem [0:(1<<AW)-1];
    logic [W-1:0]  cur [H];
    logic [W-1:0]  nxt [H];
    logic [AW-1:0] q_addr [$];
    logic [W-1:0]  q_data [$];
    logic          exp_bank = 1'b0;
    logic [15:0]   exp_gen  = '0;
    int            checks   = 0;
    int            errors   = 0;

    conway_gen_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .bank      (bank),
        .gen_count (gen_count),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    // Synchronous memory: read data appears the cycle after rd_en.
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
        if (wr_en) mem[wr_addr] = wr_data;
    end

    function automatic logic [AW-1:0] addr_of(input logic b, input int row);
        return {b, RW'(row)};
    endfunction

    task automatic clear_mem;
        for (int k = 0; k < (1 << AW); k++) mem[k] = '0;
    endtask

    task automatic compute_next;
        for (int i = 0; i < H; i++) begin
            for (int j = 0; j < W; j++) begin
                int n;
                n = 0;
                for (int di = -1; di <= 1; di++) begin
                    for (int dj = -1; dj <= 1; dj++) begin
                        int rr, cc;
                        if (di != 0 || dj != 0) begin
                            rr = (i + di + H) % H;
                            cc = j + dj;
`ifdef CONWAY_WRAP_EN
                            cc = (cc + W) % W;
`endif
                            if (cc >= 0 && cc < W) n += int'(cur[rr][cc]);
                        end
                    end
                end
                nxt[i][j] = (n == 3) || (cur[i][j] && n == 2);
            end
        end
    endtask

    // Runs one generation; abuse_cyc pulses start mid-run, reset_cyc aborts the run.
    task automatic run_gen(input int abuse_cyc, input int reset_cyc);
        int   wr_cnt, rd_cnt, done_cnt, rrow;
        logic exp_busy, exp_done, exp_wr, exp_rd;
        logic [AW-1:0] ea;
        logic [W-1:0]  ed;
        wr_cnt = 0; rd_cnt = 0; done_cnt = 0;
        for (int i = 0; i < H; i++) cur[i] = mem[addr_of(exp_bank, i)];
        compute_next();
        for (int i = 0; i < H; i++) begin
            q_addr.push_back(addr_of(~exp_bank, i));
            q_data.push_back(nxt[i]);
        end
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 2*H + 6; cyc++) begin
            @(negedge clk);
            exp_busy = (cyc <= 2*H + 4);
            exp_done = (cyc == 2*H + 4);
            exp_wr   = (cyc >= 5) && (cyc <= 2*H + 3) && (cyc % 2 == 1);
            exp_rd   = (cyc <= 3) || ((cyc >= 5) && (cyc <= 2*H + 1) && (cyc % 2 == 1));
            checks++;
            if (busy !== exp_busy) begin
                errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, exp_busy);
            end
            checks++;
            if (done !== exp_done) begin
                errors++; $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, exp_done);
            end
            checks++;
            if (wr_en !== exp_wr) begin
                errors++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", cyc, wr_en, exp_wr);
            end
            checks++;
            if (rd_en !== exp_rd) begin
                errors++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", cyc, rd_en, exp_rd);
            end
            if (rd_en === 1'b1) begin
                rd_cnt++;
                if (cyc == 1)      rrow = H - 1;
                else if (cyc == 2) rrow = 0;
                else if (cyc == 3) rrow = 1;
                else               rrow = ((cyc - 5) / 2 + 2) % H;
                ea = addr_of(exp_bank, rrow);
                checks++;
                if (rd_addr !== ea) begin
                    errors++; $display("FAIL rd_addr cyc=%0d got=%h exp=%h", cyc, rd_addr, ea);
                end
            end
            if (wr_en === 1'b1) begin
                wr_cnt++;
                checks++;
                if (q_addr.size() == 0) begin
                    errors++; $display("FAIL wr_extra cyc=%0d got addr=%h exp none", cyc, wr_addr);
                end else begin
                    ea = q_addr.pop_front();
                    ed = q_data.pop_front();
                    if (wr_addr !== ea) begin
                        errors++; $display("FAIL wr_addr cyc=%0d got=%h exp=%h", cyc, wr_addr, ea);
                    end
                    checks++;
                    if (wr_data !== ed) begin
                        errors++; $display("FAIL wr_data cyc=%0d got=%h exp=%h", cyc, wr_data, ed);
                    end
                end
            end
            if (done === 1'b1) done_cnt++;
            if (cyc == 1) start = 1'b0;
            if (cyc == abuse_cyc) start = 1'b1;
            else if (cyc == abuse_cyc + 1) start = 1'b0;
            if (cyc == reset_cyc) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                checks++;
                if (busy !== 1'b0 || bank !== 1'b0 || gen_count !== 16'd0 || wr_en !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_reset got busy=%b bank=%b gen=%0d wr=%b exp 0 0 0 0",
                             busy, bank, gen_count, wr_en);
                end
                @(negedge clk);
                reset = 1'b0;
                q_addr.delete();
                q_data.delete();
                exp_bank = 1'b0;
                exp_gen  = '0;
                for (int k = 0; k < 10; k++) begin
                    @(negedge clk);
                    checks++;
                    if (wr_en !== 1'b0 || busy !== 1'b0) begin
                        errors++; $display("FAIL post_reset got wr=%b busy=%b exp 0 0", wr_en, busy);
                    end
                end
                return;
            end
        end
        checks++;
        if (wr_cnt != H) begin
            errors++; $display("FAIL wr_count got=%0d exp=%0d", wr_cnt, H);
        end
        checks++;
        if (rd_cnt != H + 2) begin
            errors++; $display("FAIL rd_count got=%0d exp=%0d", rd_cnt, H + 2);
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL done_count got=%0d exp=1", done_cnt);
        end
        checks++;
        if (q_addr.size() != 0) begin
            errors++; $display("FAIL missing_writes got=%0d left exp=0", q_addr.size());
        end
        exp_bank = ~exp_bank;
        exp_gen  = exp_gen + 16'd1;
        checks++;
        if (bank !== exp_bank || gen_count !== exp_gen) begin
            errors++;
            $display("FAIL bank_gen got bank=%b gen=%0d exp bank=%b gen=%0d",
                     bank, gen_count, exp_bank, exp_gen);
        end
        q_addr.delete();
        q_data.delete();
    endtask

    task automatic test_reset;
        start = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bank !== 1'b0 || gen_count !== 16'd0 ||
            rd_en !== 1'b0 || wr_en !== 1'b0 || rd_addr !== '0 || wr_addr !== '0) begin
            errors++;
            $display("FAIL reset got busy=%b done=%b bank=%b gen=%0d rd=%b wr=%b ra=%h wa=%h exp all 0",
                     busy, done, bank, gen_count, rd_en, wr_en, rd_addr, wr_addr);
        end
        @(negedge clk);
        reset    = 1'b0;
        exp_bank = 1'b0;
        exp_gen  = '0;
    endtask

    task automatic test_blinker;
        logic [W-1:0] e;
        clear_mem();
        mem[addr_of(1'b0, 5)] = 32'h0000_0E00;
        run_gen(0, 0);
        for (int i = 0; i < H; i++) begin
            e = (i >= 4 && i <= 6) ? 32'h0000_0400 : 32'h0;
            checks++;
            if (mem[addr_of(1'b1, i)] !== e) begin
                errors++; $display("FAIL blinker_g1 row=%0d got=%h exp=%h", i, mem[addr_of(1'b1, i)], e);
            end
        end
        run_gen(0, 0);
        checks++;
        if (mem[addr_of(1'b0, 5)] !== 32'h0000_0E00 || mem[addr_of(1'b0, 4)] !== 32'h0) begin
            errors++;
            $display("FAIL blinker_g2 got r5=%h r4=%h exp 00000e00 00000000",
                     mem[addr_of(1'b0, 5)], mem[addr_of(1'b0, 4)]);
        end
        checks++;
        if (gen_count !== 16'd2 || bank !== 1'b0) begin
            errors++; $display("FAIL blinker_count got gen=%0d bank=%b exp 2 0", gen_count, bank);
        end
    endtask

    task automatic test_block;
        logic [W-1:0] e;
        clear_mem();
        mem[addr_of(1'b0, 10)] = 32'h0000_0018;
        mem[addr_of(1'b0, 11)] = 32'h0000_0018;
        run_gen(0, 0);
        for (int i = 0; i < H; i++) begin
            e = (i == 10 || i == 11) ? 32'h0000_0018 : 32'h0;
            checks++;
            if (mem[addr_of(1'b1, i)] !== e) begin
                errors++; $display("FAIL block row=%0d got=%h exp=%h", i, mem[addr_of(1'b1, i)], e);
            end
        end
        checks++;
        if (bank !== 1'b1) begin
            errors++; $display("FAIL block_bank got=%b exp=1", bank);
        end
    endtask

    task automatic test_edges;
        logic         src;
        logic [W-1:0] e;
        logic [W-1:0] row1;
`ifdef CONWAY_WRAP_EN
        row1 = 32'hC000_0001;
`else
        row1 = 32'hC000_0000;
`endif
        src = exp_bank;
        clear_mem();
        mem[addr_of(src, 0)]  = 32'h8000_0400;
        mem[addr_of(src, 1)]  = 32'h8000_0400;
        mem[addr_of(src, 2)]  = 32'h8000_0000;
        mem[addr_of(src, 23)] = 32'h0000_0400;
        run_gen(0, 0);
        for (int i = 0; i < H; i++) begin
            e = (i == 0) ? 32'h0000_0E00 : (i == 1) ? row1 : 32'h0;
            checks++;
            if (mem[addr_of(~src, i)] !== e) begin
                errors++; $display("FAIL edge row=%0d got=%h exp=%h", i, mem[addr_of(~src, i)], e);
            end
        end
    endtask

    task automatic test_abuse;
        test_reset();
        clear_mem();
        mem[addr_of(1'b0, 5)] = 32'h0000_0E00;
        run_gen(10, 0);
        run_gen(0, 20);
    endtask

    initial begin
        test_reset();
        test_blinker();
        test_block();
        test_edges();
        test_abuse();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
